serial_mag_comp: RTL and testbench

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

---
 rtl/serial_mag_comp.sv | 118 +++++++++++
 tb/tb_serial_mag_comp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator.
// Operands are captured on a start handshake and walked MSB first, one bit
// pair per cycle. The first differing bit decides the result immediately;
// equal operands take WIDTH cycles. The result is held until it is consumed.
module serial_mag_comp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_nxt;
    // Result flags, ordered {gt, eq, lt}; only one is ever set.
    logic [2:0]       flags_q;
    logic [2:0]       flags_nxt;

    logic a_bit;
    logic b_bit;
    logic bit_eq;

    // Bit pair under examination and its per-bit equality.
    assign a_bit  = a_q[idx];
    assign b_bit  = b_q[idx];
    assign bit_eq = (a_bit & b_bit) | (~a_bit & ~b_bit);

    // State, bit index, captured operands and result flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            idx     <= IDX_MSB;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            flags_q <= flags_nxt;
        end
    end

    // Next-state logic: accept, walk bits MSB first, hold result until taken.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a_q;
        b_nxt     = b_q;
        flags_nxt = flags_q;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    idx_nxt   = IDX_MSB;
                    flags_nxt = '0;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (!bit_eq) begin
                    // First differing bit settles the order: whichever side has the 1 is larger.
                    flags_nxt = {a_bit, 1'b0, b_bit};
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    flags_nxt = 3'b010;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - IDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    flags_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; flags are gated so they only show in DONE.
    assign start_ready = (state == IDLE);
    assign busy        = (state == COMPARE);
    assign res_valid   = (state == DONE);
    assign gt          = res_valid & flags_q[2];
    assign eq          = res_valid & flags_q[1];
    assign lt          = res_valid & flags_q[0];

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp (WIDTH=4): vector table, corner
// sequences and an exhaustive sweep, all checked through a result scoreboard.
module tb_serial_mag_comp;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         busy;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         gt;
        logic         eq;
        logic         lt;
        int           lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: unsigned magnitude order, latency = cycles to first differing bit.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        bit   found;
        e.gt  = (x > y);
        e.eq  = (x == y);
        e.lt  = (x < y);
        e.lat = W;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && (x[i] != y[i])) begin
                e.lat = W - i;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_gt"}, gt, 0);
        check({tag, "_eq"}, eq, 0);
        check({tag, "_lt"}, lt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Wait (bounded) for res_valid after an accept; returns cycles taken or -1.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < W + 2) begin
            @(posedge clk); #1;
            cyc++;
            if (!res_valid) check("busy_in_compare", busy, 1);
        end
        if (!res_valid) begin
            check("res_valid_timeout", 0, 1);
            cyc = -1;
        end
    endtask

    // Pop the scoreboard head and compare it against the presented result.
    task automatic score(input int cyc);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check("gt", gt, e.gt);
        check("eq", eq, e.eq);
        check("lt", lt, e.lt);
        check("latency", cyc, e.lat);
        check("onehot", gt + eq + lt, 1);
        check("busy_in_done", busy, 0);
    endtask

    task automatic run_compare(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input exp_t e, input int stall);
        int   cyc;
        logic hgt, heq, hlt;
        @(negedge clk);
        check("start_ready_idle", start_ready, 1);
        a           = va;
        b           = vb;
        start_valid = 1'b1;
        res_ready   = (stall == 0);
        sb_q.push_back(e);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        check("busy_after_accept", busy, 1);
        check("start_ready_after_accept", start_ready, 0);
        wait_result(cyc);
        if (cyc < 0) return;
        score(cyc);
        hgt = gt;
        heq = eq;
        hlt = lt;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_res_valid", res_valid, 1);
            check("stall_flags", {gt, eq, lt}, {hgt, heq, hlt});
            check("stall_start_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("release_res_valid", res_valid, 0);
        check("release_start_ready", start_ready, 1);
        res_ready = 1'b0;
    endtask

    initial begin
        int   cyc;
        exp_t e;

        vecs[0] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{4'b0010, 4'b0011, 1'b0, 1'b0, 1'b1, 4};
        vecs[3] = '{4'b1100, 4'b1011, 1'b1, 1'b0, 1'b0, 2};
        vecs[4] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 1};
        vecs[6] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 4};
        vecs[7] = '{4'b0111, 4'b0110, 1'b1, 1'b0, 1'b0, 4};
        vecs[8] = '{4'b1000, 4'b1010, 1'b0, 1'b0, 1'b1, 3};

        n_rst       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = '0;
        b           = '0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].lat};
            run_compare(vecs[i].a, vecs[i].b, e, i % 3);
        end

        // Held result with start_valid asserted: next accept only after release
        @(negedge clk);
        a           = 4'b0010;
        b           = 4'b0011;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        sb_q.push_back('{1'b0, 1'b0, 1'b1, 4});
        @(posedge clk); #1;
        a = 4'b0101;
        b = 4'b0101;
        wait_result(cyc);
        if (cyc >= 0) score(cyc);
        for (int i = 0; i < 5; i++) begin
            check("hold_lt", lt, 1);
            check("hold_res_valid", res_valid, 1);
            check("hold_start_ready", start_ready, 0);
            @(posedge clk); #1;
        end
        check("hold_end_lt", lt, 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_idle", start_ready, 1);
        check("hold_release_busy", busy, 0);
        check("hold_release_valid", res_valid, 0);
        sb_q.push_back('{1'b0, 1'b1, 1'b0, 4});
        @(posedge clk); #1;
        check("reaccept_busy", busy, 1);
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        wait_result(cyc);
        if (cyc >= 0) score(cyc);
        @(posedge clk); #1;
        check("reaccept_release_idle", start_ready, 1);
        res_ready = 1'b0;

        // Asynchronous reset in the middle of a compare
        @(negedge clk);
        a           = 4'b0101;
        b           = 4'b0101;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("in_reset_res_valid", res_valid, 0);
            check("in_reset_start_ready", start_ready, 1);
        end
        @(negedge clk);
        n_rst     = 1'b1;
        res_ready = 1'b0;
        run_compare(4'b0001, 4'b0000, '{1'b1, 1'b0, 1'b0, 4}, 0);

        // Exhaustive sweep with random consumer stalls
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_compare(W'(ia), W'(ib), model(W'(ia), W'(ib)), int'($urandom_range(0, 2)));
            end
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
